// File: rtl/wr_burst_sched.sv
// Two-channel memory write scheduler.
// Grants whole bursts round-robin to channels whose FIFO holds a full burst,
// issues one write command per burst at a per-channel circular address, then
// streams exactly BL beats from the granted FIFO to the memory write port.
module wr_burst_sched #(
  parameter int unsigned DSIZE   = 36,
  parameter int unsigned AW      = 25,
  parameter int unsigned BL      = 16,
  parameter int unsigned GAP_CYC = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       ch_en_i,
  input  logic             restart_i,
  input  logic [AW-1:0]    base_addr0_i,
  input  logic [AW-1:0]    base_addr1_i,
  input  logic [AW-1:0]    region_len0_i,
  input  logic [AW-1:0]    region_len1_i,
  input  logic [1:0]       burst_avail_i,
  output logic [1:0]       burst_rd_en_o,
  input  logic [DSIZE-1:0] burst_rd_data0_i,
  input  logic [DSIZE-1:0] burst_rd_data1_i,
  output logic             cmd_vld_o,
  input  logic             cmd_rdy_i,
  output logic [AW-1:0]    cmd_addr_o,
  output logic             wr_vld_o,
  input  logic             wr_rdy_i,
  output logic [DSIZE-1:0] wr_data_o,
  output logic             wr_last_o,
  output logic [1:0]       wrap_o,
  output logic             busy_o
);

  localparam int unsigned BW = (BL > 1) ? $clog2(BL) : 1;
  localparam int unsigned GW = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
  localparam logic [BW-1:0] BEAT_LAST = BW'(BL - 1);
  localparam logic [GW-1:0] GAP_LAST  = GW'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);
  localparam logic [AW:0]   BL_W      = (AW+1)'(BL);

  typedef enum logic [1:0] {
    IDLE,
    CMD,
    DATA,
    GAP
  } state_t;

  state_t        state_q;
  state_t        state_nxt;
  logic          grant_q;
  logic          last_grant_q;
  logic [AW-1:0] off0_q;
  logic [AW-1:0] off1_q;
  logic [BW-1:0] beat_q;
  logic [GW-1:0] gap_q;
  logic          restart_pend_q;
  logic [1:0]    wrap_q;

  logic [1:0]    req;
  logic          arb_ch;
  logic [AW-1:0] cur_off;
  logic [AW-1:0] cur_base;
  logic [AW-1:0] cur_len;
  logic [AW:0]   off_inc;
  logic          burst_wraps;
  logic [AW-1:0] off_next_g;
  logic          wr_hs;
  logic          last_hs;
  logic          gap_done;
  logic          restart_now;
  logic          apply_restart;

  assign req         = burst_avail_i & ch_en_i;
  // Both requesting: the channel not served last time wins.
  assign arb_ch      = (req == 2'b11) ? ~last_grant_q : req[1];
  assign cur_off     = grant_q ? off1_q : off0_q;
  assign cur_base    = grant_q ? base_addr1_i : base_addr0_i;
  assign cur_len     = grant_q ? region_len1_i : region_len0_i;
  // One extra bit so the compare against region length cannot overflow.
  assign off_inc     = {1'b0, cur_off} + BL_W;
  assign burst_wraps = off_inc >= {1'b0, cur_len};
  assign off_next_g  = burst_wraps ? '0 : off_inc[AW-1:0];
  assign wr_hs       = (state_q == DATA) && wr_rdy_i;
  assign last_hs     = wr_hs && (beat_q == BEAT_LAST);
  assign gap_done    = (state_q == GAP) && (gap_q == GAP_LAST);
  // Outside a burst a restart takes effect at once; inside, it waits for GAP entry.
  assign restart_now   = restart_i && ((state_q == IDLE) || (state_q == GAP));
  assign apply_restart = last_hs && (restart_pend_q || restart_i);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_nxt;
    end
  end

  // Next-state decode.
  always_comb begin
    state_nxt = state_q;
    case (state_q)
      IDLE:    if (req != 2'b00) state_nxt = CMD;
      CMD:     if (cmd_rdy_i)    state_nxt = DATA;
      DATA:    if (last_hs)      state_nxt = GAP;
      GAP:     if (gap_done)     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Grant latch, beat counter and post-burst gap counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
      beat_q       <= '0;
      gap_q        <= '0;
    end else begin
      if ((state_q == IDLE) && (req != 2'b00)) begin
        grant_q      <= arb_ch;
        last_grant_q <= arb_ch;
      end
      if (wr_hs) begin
        beat_q <= last_hs ? '0 : beat_q + BW'(1);
      end
      if (state_q == GAP) begin
        gap_q <= gap_done ? '0 : gap_q + GW'(1);
      end else begin
        gap_q <= '0;
      end
    end
  end

  // Per-channel circular offsets, deferred restart and wrap pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      off0_q         <= '0;
      off1_q         <= '0;
      restart_pend_q <= 1'b0;
      wrap_q         <= '0;
    end else begin
      if (restart_now || apply_restart) begin
        off0_q <= '0;
        off1_q <= '0;
      end else if (last_hs) begin
        if (grant_q) begin
          off1_q <= off_next_g;
        end else begin
          off0_q <= off_next_g;
        end
      end
      if (last_hs) begin
        restart_pend_q <= 1'b0;
      end else if (restart_i && ((state_q == CMD) || (state_q == DATA))) begin
        restart_pend_q <= 1'b1;
      end
      // Wrap still reports even when a restart zeroes the offsets on the same edge.
      if (last_hs && burst_wraps) begin
        wrap_q <= grant_q ? 2'b10 : 2'b01;
      end else begin
        wrap_q <= '0;
      end
    end
  end

  // Output decode from state; everything idles at zero outside its phase.
  always_comb begin
    cmd_vld_o     = 1'b0;
    cmd_addr_o    = '0;
    wr_vld_o      = 1'b0;
    wr_data_o     = '0;
    wr_last_o     = 1'b0;
    burst_rd_en_o = 2'b00;
    case (state_q)
      CMD: begin
        cmd_vld_o  = 1'b1;
        cmd_addr_o = cur_base + cur_off;
      end
      DATA: begin
        wr_vld_o      = 1'b1;
        wr_data_o     = grant_q ? burst_rd_data1_i : burst_rd_data0_i;
        wr_last_o     = (beat_q == BEAT_LAST);
        burst_rd_en_o = grant_q ? {wr_rdy_i, 1'b0} : {1'b0, wr_rdy_i};
      end
      default: ;
    endcase
  end

  assign busy_o = (state_q != IDLE);
  assign wrap_o = wrap_q;

endmodule
